temperature_sample_accumulator: RTL and testbench

//  - Front end of the temperature averaging path: accepts raw sensor samples

---
 rtl/temperature_pkg.sv | 13 +
 rtl/temperature_sample_accumulator_if.sv | 43 ++++
 rtl/temperature_sample_accumulator.sv | 92 +++++++++
 tb/tb_temperature_sample_accumulator.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/temperature_pkg.sv
// Shared constants for the temperature averaging path.
// The block size and the downstream divider shift both come from here, so they cannot diverge.
`default_nettype none

package temperature_pkg;

  localparam int TEMP_SAMPLE_W     = 16;
  localparam int TEMP_LOG2_SAMPLES = 6;
  localparam int TEMP_SUM_W        = 32;

endpackage : temperature_pkg

`default_nettype wire

// File: rtl/temperature_sample_accumulator_if.sv
// Sample-in / block-sum-out handshake bundle for the temperature accumulator.
// The slave modport is the accumulator's view; the master modport is its environment's view.
`default_nettype none

interface temperature_sample_accumulator_if
  import temperature_pkg::*;
#(
  parameter int SAMPLE_W     = TEMP_SAMPLE_W,
  parameter int LOG2_SAMPLES = TEMP_LOG2_SAMPLES,
  parameter int SUM_W        = TEMP_SUM_W
);

  logic                    in_valid;
  logic                    in_ready;
  logic [SAMPLE_W-1:0]     in_sample;
  logic                    out_valid;
  logic                    out_ready;
  logic [SUM_W-1:0]        out_sum;
  logic [LOG2_SAMPLES-1:0] sample_cnt;

  modport slave (
    input  in_valid,
    input  in_sample,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_sum,
    output sample_cnt
  );

  modport master (
    output in_valid,
    output in_sample,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_sum,
    input  sample_cnt
  );

endinterface : temperature_sample_accumulator_if

`default_nettype wire

// File: rtl/temperature_sample_accumulator.sv
// Sums blocks of 2**LOG2_SAMPLES unsigned samples and hands each block sum downstream.
// Only the block-completing sample stalls while an earlier sum is still pending.
`default_nettype none

module temperature_sample_accumulator
  import temperature_pkg::*;
#(
  parameter int SAMPLE_W     = TEMP_SAMPLE_W,
  parameter int LOG2_SAMPLES = TEMP_LOG2_SAMPLES,
  parameter int SUM_W        = TEMP_SUM_W
) (
  input  wire logic                         clk,
  input  wire logic                         reset,
  input  wire logic                         clear,
  temperature_sample_accumulator_if.slave   bus
);

  generate
    if (SUM_W < SAMPLE_W + LOG2_SAMPLES) begin : g_width_check
      $error("temperature_sample_accumulator: SUM_W too narrow for a full block sum");
    end
  endgenerate

  localparam logic [LOG2_SAMPLES-1:0] LAST_CNT = {LOG2_SAMPLES{1'b1}};

  logic [SUM_W-1:0]        acc_q, acc_d;
  logic [LOG2_SAMPLES-1:0] sample_cnt_q, sample_cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic [SUM_W-1:0]        out_sum_q, out_sum_d;

  logic                    last_sample;
  logic                    in_ready;
  logic                    accept;
  logic [SUM_W-1:0]        sample_ext;
  logic [SUM_W-1:0]        acc_next;

  assign last_sample = (sample_cnt_q == LAST_CNT);
  // Stall only the completing sample, and only if the pending sum is not being drained now.
  assign in_ready    = !(last_sample && out_valid_q && !bus.out_ready);
  assign accept      = bus.in_valid && in_ready && !clear;
  assign sample_ext  = {{(SUM_W-SAMPLE_W){1'b0}}, bus.in_sample};
  assign acc_next    = acc_q + sample_ext;

  always_comb begin
    acc_d        = acc_q;
    sample_cnt_d = sample_cnt_q;
    out_valid_d  = out_valid_q;
    out_sum_d    = out_sum_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clear) begin
      acc_d        = '0;
      sample_cnt_d = '0;
    end else if (accept) begin
      if (last_sample) begin
        // A new sum overrides the drain above, so a simultaneous drain+load has no bubble.
        out_sum_d    = acc_next;
        out_valid_d  = 1'b1;
        acc_d        = '0;
        sample_cnt_d = '0;
      end else begin
        acc_d        = acc_next;
        sample_cnt_d = sample_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q        <= '0;
      sample_cnt_q <= '0;
      out_valid_q  <= 1'b0;
      out_sum_q    <= '0;
    end else begin
      acc_q        <= acc_d;
      sample_cnt_q <= sample_cnt_d;
      out_valid_q  <= out_valid_d;
      out_sum_q    <= out_sum_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_sum    = out_sum_q;
  assign bus.sample_cnt = sample_cnt_q;

endmodule : temperature_sample_accumulator

`default_nettype wire

// File: tb/tb_temperature_sample_accumulator.sv
// Directed self-checking bench for temperature_sample_accumulator.
`default_nettype none

module tb_temperature_sample_accumulator;
  import temperature_pkg::*;

  logic clk;
  logic reset;
  logic clear;

  int tests_run;
  int tests_failed;

  temperature_sample_accumulator_if bus ();

  temperature_sample_accumulator dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", tag, act, act, exp, exp);
    end
  endtask

  // Offer one sample from the next falling edge; returns after the rising edge that accepts it.
  task automatic send(input logic [15:0] s);
    int budget;
    budget = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_sample = s;
    #1;
    while (!bus.in_ready && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (!bus.in_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_n(input int n, input logic [15:0] s);
    for (int i = 0; i < n; i++) send(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    check("rst_cnt",      32'(bus.sample_cnt), 32'd0);
    check("rst_valid",    32'(bus.out_valid),  32'd0);
    check("rst_sum",      bus.out_sum,         32'd0);
    check("rst_in_ready", 32'(bus.in_ready),   32'd1);

    // 1. reset mid-block
    send_n(10, 16'd100);
    check("mid_cnt", 32'(bus.sample_cnt), 32'd10);
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("async_rst_cnt",   32'(bus.sample_cnt), 32'd0);
    check("async_rst_valid", 32'(bus.out_valid),  32'd0);
    check("async_rst_sum",   bus.out_sum,         32'd0);
    @(negedge clk);
    reset = 1'b0;
    send_n(63, 16'd100);
    check("t1_no_early_valid", 32'(bus.out_valid), 32'd0);
    send(16'd100);
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_sum",   bus.out_sum,        32'd6400);
    idle(1);
    check("t1_drained", 32'(bus.out_valid), 32'd0);

    // 2. basic block and divider view
    send_n(63, 16'd25);
    check("t2_cnt63", 32'(bus.sample_cnt), 32'd63);
    send(16'd25);
    check("t2_valid", 32'(bus.out_valid),  32'd1);
    check("t2_sum",   bus.out_sum,         32'd1600);
    check("t2_mean",  bus.out_sum >> TEMP_LOG2_SAMPLES, 32'd25);
    check("t2_cnt_wrap", 32'(bus.sample_cnt), 32'd0);
    idle(1);
    check("t2_drained",  32'(bus.out_valid), 32'd0);
    check("t2_sum_kept", bus.out_sum,        32'd1600);

    // 3. full-scale samples
    send_n(64, 16'hFFFF);
    check("t3_sum", bus.out_sum, 32'h003F_FFC0);
    idle(1);

    // 4/5. backpressure, then drain and load on the same edge
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_n(64, 16'd1);
    check("t4_sum1", bus.out_sum, 32'd64);
    send_n(63, 16'd2);
    check("t4_cnt63",  32'(bus.sample_cnt), 32'd63);
    check("t4_held_v", 32'(bus.out_valid),  32'd1);
    check("t4_held_s", bus.out_sum,         32'd64);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'd2;
    #1;
    check("t4_stall", 32'(bus.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_stall_cnt", 32'(bus.sample_cnt), 32'd63);
    check("t4_stall_sum", bus.out_sum,         32'd64);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    check("t4_ready_comb", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("t5_valid_kept", 32'(bus.out_valid), 32'd1);
    check("t5_sum2",       bus.out_sum,        32'd128);
    check("t5_cnt0",       32'(bus.sample_cnt), 32'd0);
    idle(1);
    check("t5_drained", 32'(bus.out_valid), 32'd0);

    // 6. clear with a pending sum
    @(negedge clk);
    bus.out_ready = 1'b0;
    send_n(64, 16'd4);
    send_n(30, 16'd7);
    check("t6_cnt30", 32'(bus.sample_cnt), 32'd30);
    @(negedge clk);
    clear         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_sample = 16'd7;
    @(posedge clk);
    #1;
    check("t6_clear_cnt", 32'(bus.sample_cnt), 32'd0);
    check("t6_pending_v", 32'(bus.out_valid),  32'd1);
    check("t6_pending_s", bus.out_sum,         32'd256);
    @(negedge clk);
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t6_drained", 32'(bus.out_valid), 32'd0);
    send_n(64, 16'd3);
    check("t6_valid", 32'(bus.out_valid), 32'd1);
    check("t6_sum",   bus.out_sum,        32'd192);
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_temperature_sample_accumulator

`default_nettype wire
